// File: rtl/pic_rw_control.sv
// pic_rw_control: read/write control and initialization sequencer for the PIC CPU interface.
//
// Synchronizes the CPU bus strobes, drives the data-bus buffer RD/WR flags, decodes committed
// writes into ICW1-ICW4 / OCW1-OCW3, holds the initialization configuration and selects the
// register returned on reads.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   CS_n, RD_n, WR_n    CPU chip select / read / write strobes (active low)
//   A0, Ds_IN           CPU address bit 0 and write data
//   RD_flag, WR_flag    registered read / write enables to the data-bus buffer
//   icw_wr, ocw_wr      one-cycle commit strobes, bit n = ICW(n+1) / OCW(n+1)
//   wr_data             data of the last committed write
//   icw1_reg, vector_base, icw3_reg, icw4_reg, imr   stored configuration words
//   rd_sel              read source: 00 IRR, 01 ISR, 10 IMR, 11 poll
//   init_done           initialization sequence complete

module pic_rw_control #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       A0,
    input  logic [7:0] Ds_IN,
    output logic       RD_flag,
    output logic       WR_flag,
    output logic [3:0] icw_wr,
    output logic [2:0] ocw_wr,
    output logic [7:0] wr_data,
    output logic [7:0] icw1_reg,
    output logic [4:0] vector_base,
    output logic [7:0] icw3_reg,
    output logic [7:0] icw4_reg,
    output logic [7:0] imr,
    output logic [1:0] rd_sel,
    output logic       init_done
);

    typedef enum logic [2:0] {
        StUninit,
        StWaitIcw2,
        StWaitIcw3,
        StWaitIcw4,
        StReady
    } state_t;

    // Synchronizer chains; the last stage is the usable copy.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] a0_sync;

    logic cs_s, rd_s, wr_s, a0_s;
    logic wr_act, rd_act;
    logic commit, rd_end;

    state_t     state;
    logic       hold_a0;
    logic [7:0] hold_data;
    logic       poll;
    logic [1:0] sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            a0_sync <= '0;
        end else begin
            cs_sync[0] <= CS_n;
            rd_sync[0] <= RD_n;
            wr_sync[0] <= WR_n;
            a0_sync[0] <= A0;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i] <= cs_sync[i-1];
                rd_sync[i] <= rd_sync[i-1];
                wr_sync[i] <= wr_sync[i-1];
                a0_sync[i] <= a0_sync[i-1];
            end
        end
    end

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign rd_s = rd_sync[SYNC_STAGES-1];
    assign wr_s = wr_sync[SYNC_STAGES-1];
    assign a0_s = a0_sync[SYNC_STAGES-1];

    // RD and WR low together qualifies neither.
    assign wr_act = ~cs_s & ~wr_s & rd_s;
    assign rd_act = ~cs_s & ~rd_s & wr_s;

    // WR_flag/RD_flag are the registered activity, so they double as the edge-detect history.
    assign commit = WR_flag & ~wr_act;
    assign rd_end = RD_flag & ~rd_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StUninit;
            RD_flag     <= 1'b0;
            WR_flag     <= 1'b0;
            hold_a0     <= 1'b0;
            hold_data   <= 8'h00;
            icw_wr      <= 4'b0000;
            ocw_wr      <= 3'b000;
            wr_data     <= 8'h00;
            icw1_reg    <= 8'h00;
            vector_base <= 5'h00;
            icw3_reg    <= 8'h00;
            icw4_reg    <= 8'h00;
            imr         <= 8'h00;
            poll        <= 1'b0;
            sel_q       <= 2'b00;
            init_done   <= 1'b0;
        end else begin
            RD_flag <= rd_act;
            WR_flag <= wr_act;
            icw_wr  <= 4'b0000;
            ocw_wr  <= 3'b000;

            if (wr_act) begin
                hold_a0   <= a0_s;
                hold_data <= Ds_IN;
            end

            // Poll mode lasts for exactly one read; a later OCW3 in this cycle may re-arm it.
            if (rd_end) begin
                poll <= 1'b0;
            end

            if (commit) begin
                if (!hold_a0 && hold_data[4]) begin
                    // ICW1 restarts initialization from any state.
                    icw_wr    <= 4'b0001;
                    wr_data   <= hold_data;
                    icw1_reg  <= hold_data;
                    imr       <= 8'h00;
                    sel_q     <= 2'b00;
                    poll      <= 1'b0;
                    init_done <= 1'b0;
                    if (!hold_data[0]) begin
                        icw4_reg <= 8'h00;
                    end
                    state <= StWaitIcw2;
                end else if (hold_a0) begin
                    case (state)
                        StWaitIcw2: begin
                            icw_wr      <= 4'b0010;
                            wr_data     <= hold_data;
                            vector_base <= hold_data[7:3];
                            if (!icw1_reg[1]) begin
                                state <= StWaitIcw3;
                            end else if (icw1_reg[0]) begin
                                state <= StWaitIcw4;
                            end else begin
                                state     <= StReady;
                                init_done <= 1'b1;
                            end
                        end
                        StWaitIcw3: begin
                            icw_wr   <= 4'b0100;
                            wr_data  <= hold_data;
                            icw3_reg <= hold_data;
                            if (icw1_reg[0]) begin
                                state <= StWaitIcw4;
                            end else begin
                                state     <= StReady;
                                init_done <= 1'b1;
                            end
                        end
                        StWaitIcw4: begin
                            icw_wr    <= 4'b1000;
                            wr_data   <= hold_data;
                            icw4_reg  <= hold_data;
                            state     <= StReady;
                            init_done <= 1'b1;
                        end
                        StReady: begin
                            ocw_wr  <= 3'b001;
                            wr_data <= hold_data;
                            imr     <= hold_data;
                        end
                        default: ;
                    endcase
                end else if (state == StReady) begin
                    wr_data <= hold_data;
                    if (hold_data[3]) begin
                        ocw_wr <= 3'b100;
                        if (hold_data[2]) begin
                            poll <= 1'b1;
                        end
                        if (hold_data[1]) begin
                            sel_q <= {1'b0, hold_data[0]};
                        end
                    end else begin
                        ocw_wr <= 3'b010;
                    end
                end
            end
        end
    end

    // A0=1 reads always return the mask; poll overrides everything.
    always_comb begin
        rd_sel = sel_q;
        if (poll) begin
            rd_sel = 2'b11;
        end else if (a0_s) begin
            rd_sel = 2'b10;
        end
    end

endmodule

// File: tb/tb_pic_rw_control.sv
// Testbench for pic_rw_control: directed vector table, hand-written corner sequences and
// randomized bus transactions checked against a transaction-level reference model.

module tb_pic_rw_control;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       CS_n, RD_n, WR_n, A0;
    logic [7:0] Ds_IN;
    logic       RD_flag, WR_flag;
    logic [3:0] icw_wr;
    logic [2:0] ocw_wr;
    logic [7:0] wr_data, icw1_reg, icw3_reg, icw4_reg, imr;
    logic [4:0] vector_base;
    logic [1:0] rd_sel;
    logic       init_done;

    pic_rw_control #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .CS_n        (CS_n),
        .RD_n        (RD_n),
        .WR_n        (WR_n),
        .A0          (A0),
        .Ds_IN       (Ds_IN),
        .RD_flag     (RD_flag),
        .WR_flag     (WR_flag),
        .icw_wr      (icw_wr),
        .ocw_wr      (ocw_wr),
        .wr_data     (wr_data),
        .icw1_reg    (icw1_reg),
        .vector_base (vector_base),
        .icw3_reg    (icw3_reg),
        .icw4_reg    (icw4_reg),
        .imr         (imr),
        .rd_sel      (rd_sel),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] m_icw1, m_icw3, m_icw4, m_imr;
    logic [4:0] m_vb;
    logic       m_init, m_poll, m_a0;
    logic [1:0] m_sel;
    int         pending[$];   // ICW numbers still expected, in order

    logic [3:0] e_icw;
    logic [2:0] e_ocw;
    logic [1:0] e_rsel;

    task automatic model_reset();
        m_icw1 = 0; m_icw3 = 0; m_icw4 = 0; m_imr = 0; m_vb = 0;
        m_init = 0; m_poll = 0; m_a0 = 0; m_sel = 0;
        pending.delete();
    endtask

    function automatic logic [1:0] model_rdsel();
        if (m_poll) return 2'b11;
        if (m_a0) return 2'b10;
        return m_sel;
    endfunction

    task automatic model_write(input logic a0, input logic [7:0] d);
        int n;
        e_icw = 0;
        e_ocw = 0;
        if (!a0 && d[4]) begin
            m_icw1 = d; m_imr = 0; m_sel = 0; m_poll = 0; m_init = 0;
            if (!d[0]) m_icw4 = 0;
            pending.delete();
            pending.push_back(2);
            if (!d[1]) pending.push_back(3);
            if (d[0]) pending.push_back(4);
            e_icw = 4'b0001;
        end else if (pending.size() > 0) begin
            if (a0) begin
                n = pending.pop_front();
                if (n == 2) m_vb = d[7:3];
                if (n == 3) m_icw3 = d;
                if (n == 4) m_icw4 = d;
                e_icw = 4'(1 << (n - 1));
                if (pending.size() == 0) m_init = 1;
            end
        end else if (m_init) begin
            if (a0) begin
                m_imr = d;
                e_ocw = 3'b001;
            end else if (!d[3]) begin
                e_ocw = 3'b010;
            end else begin
                e_ocw = 3'b100;
                if (d[2]) m_poll = 1;
                if (d[1]) m_sel = {1'b0, d[0]};
            end
        end
    endtask

    // ---------------- bus drivers ----------------
    int         o_nstr;
    logic [3:0] o_icw;
    logic [2:0] o_ocw;
    logic [7:0] o_wd;
    logic       o_fl_on, o_fl_late, o_fl_off;
    logic [1:0] o_rsel;

    task automatic watch_window(input logic is_rd);
        o_nstr = 0; o_icw = 0; o_ocw = 0; o_wd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == S) o_fl_late = is_rd ? RD_flag : WR_flag;
            if (i == S + 1) o_fl_off = is_rd ? RD_flag : WR_flag;
            if (icw_wr != 0 || ocw_wr != 0) begin
                if (o_nstr == 0) begin
                    o_icw = icw_wr; o_ocw = ocw_wr; o_wd = wr_data;
                end
                o_nstr++;
            end
        end
    endtask

    task automatic bus_cycle(input logic is_rd, input logic a0, input logic [7:0] d,
                             input int hold);
        @(posedge clk); #1;
        A0 = a0; Ds_IN = d; CS_n = 0;
        if (is_rd) RD_n = 0; else WR_n = 0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        o_fl_on = is_rd ? RD_flag : WR_flag;
        o_rsel  = rd_sel;
        @(posedge clk); #1;
        RD_n = 1; WR_n = 1; CS_n = 1;
        watch_window(is_rd);
    endtask

    // Runs one transaction on the bus and through the model; expectations land in e_*.
    task automatic run_txn(input logic is_rd, input logic a0, input logic [7:0] d,
                           input int hold);
        m_a0 = a0;
        if (is_rd) begin
            e_icw = 0; e_ocw = 0;
            e_rsel = model_rdsel();
            m_poll = 0;
        end else begin
            model_write(a0, d);
        end
        bus_cycle(is_rd, a0, d, hold);
    endtask

    task automatic check_model(input string tag, input logic is_rd, input logic [7:0] d);
        chk({tag, "_nstr"}, 32'(o_nstr), (e_icw != 0 || e_ocw != 0) ? 32'd1 : 32'd0);
        chk({tag, "_icw"}, 32'(o_icw), 32'(e_icw));
        chk({tag, "_ocw"}, 32'(o_ocw), 32'(e_ocw));
        if (e_icw != 0 || e_ocw != 0) chk({tag, "_wd"}, 32'(o_wd), 32'(d));
        chk({tag, "_flon"}, 32'(o_fl_on), 32'd1);
        chk({tag, "_fllate"}, 32'(o_fl_late), 32'd1);
        chk({tag, "_floff"}, 32'(o_fl_off), 32'd0);
        if (is_rd) chk({tag, "_rsel_rd"}, 32'(o_rsel), 32'(e_rsel));
        chk({tag, "_icw1"}, 32'(icw1_reg), 32'(m_icw1));
        chk({tag, "_vb"}, 32'(vector_base), 32'(m_vb));
        chk({tag, "_icw3"}, 32'(icw3_reg), 32'(m_icw3));
        chk({tag, "_icw4"}, 32'(icw4_reg), 32'(m_icw4));
        chk({tag, "_imr"}, 32'(imr), 32'(m_imr));
        chk({tag, "_init"}, 32'(init_done), 32'(m_init));
        chk({tag, "_rsel"}, 32'(rd_sel), 32'(model_rdsel()));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({RD_flag, WR_flag}), 32'd0);
        chk({tag, "_strb"}, 32'({icw_wr, ocw_wr}), 32'd0);
        chk({tag, "_wd"}, 32'(wr_data), 32'd0);
        chk({tag, "_cfg"}, {icw1_reg, icw3_reg, icw4_reg, imr}, 32'd0);
        chk({tag, "_vb"}, 32'(vector_base), 32'd0);
        chk({tag, "_rsel"}, 32'(rd_sel), 32'd0);
        chk({tag, "_init"}, 32'(init_done), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rd;
        logic       a0;
        logic [7:0] d;
        logic [3:0] icw;
        logic [2:0] ocw;
        logic [1:0] rsel;   // rd_sel during a read
        logic [1:0] sel;    // rd_sel after the transaction
        logic       init;
        logic [7:0] imr;
        logic [4:0] vb;
        logic [7:0] icw4;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [7:0] d;
        logic       a0, is_rd;
        string      tag;

        tbl[0]  = '{1'b0, 1'b0, 8'h13, 4'b0001, 3'b000, 2'b00, 2'b00, 1'b0, 8'h00, 5'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h48, 4'b0010, 3'b000, 2'b00, 2'b10, 1'b0, 8'h00, 5'h09, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h03, 4'b1000, 3'b000, 2'b00, 2'b10, 1'b1, 8'h00, 5'h09, 8'h03};
        tbl[3]  = '{1'b0, 1'b0, 8'h10, 4'b0001, 3'b000, 2'b00, 2'b00, 1'b0, 8'h00, 5'h09, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 8'h20, 4'b0010, 3'b000, 2'b00, 2'b10, 1'b0, 8'h00, 5'h04, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 8'h04, 4'b0100, 3'b000, 2'b00, 2'b10, 1'b1, 8'h00, 5'h04, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'hA5, 4'b0000, 3'b001, 2'b00, 2'b10, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h0B, 4'b0000, 3'b100, 2'b00, 2'b01, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[8]  = '{1'b1, 1'b1, 8'h00, 4'b0000, 3'b000, 2'b10, 2'b10, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h0C, 4'b0000, 3'b100, 2'b00, 2'b11, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 4'b0000, 3'b000, 2'b11, 2'b01, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h20, 4'b0000, 3'b010, 2'b00, 2'b01, 1'b1, 8'hA5, 5'h04, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 8'h13, 4'b0001, 3'b000, 2'b00, 2'b00, 1'b0, 8'h00, 5'h04, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 8'h00, 5'h04, 8'h00};
        tbl[14] = '{1'b0, 1'b1, 8'h48, 4'b0010, 3'b000, 2'b00, 2'b10, 1'b0, 8'h00, 5'h09, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 8'h01, 4'b1000, 3'b000, 2'b00, 2'b10, 1'b1, 8'h00, 5'h09, 8'h01};

        // Reset state
        reset_n = 0; CS_n = 1; RD_n = 1; WR_n = 1; A0 = 0; Ds_IN = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_n = 1;
        repeat (2) @(posedge clk);

        // Directed table
        for (int k = 0; k < 16; k++) begin
            run_txn(tbl[k].rd, tbl[k].a0, tbl[k].d, int'(S) + 1 + (k % 3));
            tag = $sformatf("row%0d", k);
            chk({tag, "_nstr"}, 32'(o_nstr),
                (tbl[k].icw != 0 || tbl[k].ocw != 0) ? 32'd1 : 32'd0);
            chk({tag, "_icw"}, 32'(o_icw), 32'(tbl[k].icw));
            chk({tag, "_ocw"}, 32'(o_ocw), 32'(tbl[k].ocw));
            if (tbl[k].icw != 0 || tbl[k].ocw != 0) chk({tag, "_wd"}, 32'(o_wd), 32'(tbl[k].d));
            chk({tag, "_flon"}, 32'(o_fl_on), 32'd1);
            chk({tag, "_floff"}, 32'(o_fl_off), 32'd0);
            if (tbl[k].rd) chk({tag, "_rsel_rd"}, 32'(o_rsel), 32'(tbl[k].rsel));
            chk({tag, "_rsel"}, 32'(rd_sel), 32'(tbl[k].sel));
            chk({tag, "_init"}, 32'(init_done), 32'(tbl[k].init));
            chk({tag, "_imr"}, 32'(imr), 32'(tbl[k].imr));
            chk({tag, "_vb"}, 32'(vector_base), 32'(tbl[k].vb));
            chk({tag, "_icw4"}, 32'(icw4_reg), 32'(tbl[k].icw4));
        end

        // RD and WR low together: no flags, no strobe, nothing changes
        @(posedge clk); #1;
        Ds_IN = 8'h5A; CS_n = 0; RD_n = 0; WR_n = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("inv_flags", 32'({RD_flag, WR_flag}), 32'd0);
        @(posedge clk); #1;
        CS_n = 1; RD_n = 1; WR_n = 1;
        watch_window(1'b0);
        chk("inv_nstr", 32'(o_nstr), 32'd0);
        chk("inv_imr", 32'(imr), 32'(m_imr));
        chk("inv_init", 32'(init_done), 32'(m_init));

        // CS_n rising ahead of WR_n still commits (OCW1 in READY)
        model_write(1'b1, 8'h3C);
        m_a0 = 1;
        @(posedge clk); #1;
        A0 = 1; Ds_IN = 8'h3C; CS_n = 0; WR_n = 0;
        repeat (S + 2) @(posedge clk);
        #1; CS_n = 1;
        @(posedge clk); #1; WR_n = 1;
        watch_window(1'b0);
        chk("csfirst_nstr", 32'(o_nstr), 32'd1);
        chk("csfirst_ocw", 32'(o_ocw), 32'(e_ocw));
        chk("csfirst_imr", 32'(imr), 32'(m_imr));

        // Reset in the middle of a write: outputs clear, no strobe after release
        @(posedge clk); #1;
        A0 = 1; Ds_IN = 8'h5A; CS_n = 0; WR_n = 0;
        repeat (S + 3) @(posedge clk);
        #2; reset_n = 0;
        #1; check_all_zero("midrst");
        @(posedge clk); #1;
        CS_n = 1; WR_n = 1; A0 = 0;
        repeat (2) @(posedge clk);
        #1; reset_n = 1;
        model_reset();
        watch_window(1'b0);
        chk("midrst_nstr", 32'(o_nstr), 32'd0);
        check_all_zero("midrst_after");

        // Randomized transactions against the model
        for (int t = 0; t < 200; t++) begin
            is_rd = ($urandom_range(0, 9) < 3);
            a0    = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            if (!is_rd && !a0) d[4] = ($urandom_range(0, 3) == 0);
            run_txn(is_rd, a0, d, int'(S) + 1 + int'($urandom_range(0, 3)));
            check_model($sformatf("rnd%0d", t), is_rd, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
